ds_arb: RTL and testbench

DS_ARB -- requirements
Module: ds_arb

---
 rtl/ds_arb_if.sv | 25 ++
 rtl/ds_arb.sv | 171 +++++++++++++++++
 tb/tb_ds_arb.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ds_arb_if.sv
// ds_arb_pkg : width helper shared by the arbiter.
// ds_if      : valid/ready stream carrying a DTYPE payload.
//              slv = stream consumer side, mst = stream producer side.
package ds_arb_pkg;

   // Bits needed to encode n distinct values, never fewer than one.
   function automatic int sclog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

interface ds_if #(
   parameter type DTYPE = logic [7:0]
) ();
   logic vld;
   logic rdy;
   DTYPE data;

   modport slv (input vld, input data, output rdy);
   modport mst (output vld, output data, input rdy);
endinterface

// File: rtl/ds_arb.sv
// ds_arb: round-robin merge of SLV_CNT valid/ready streams into one, with
// grants held for bursts of up to BURST_MAX beats.
// Optional feature: define DS_ARB_SKID_EN to register the egress through a
// 2-entry skid buffer (1-cycle latency, no if_mst.rdy -> if_slv.rdy path).
// Default build: egress is combinational from the granted source.
module ds_arb
   import ds_arb_pkg::*;
#(
   parameter int  SLV_CNT   = 4,
   parameter type DTYPE     = logic [7:0],
   parameter int  BURST_MAX = 1,
   localparam int SLV_IDX_WIDTH = sclog2(SLV_CNT)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   ds_if.slv                        if_slv [SLV_CNT-1:0],
   ds_if.mst                        if_mst,
   output logic [SLV_IDX_WIDTH-1:0] o_mst_src
);

   localparam int                       CNT_W    = sclog2(BURST_MAX) + 1;
   localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(BURST_MAX - 1);
   localparam logic [SLV_IDX_WIDTH-1:0] PTR_RST  = SLV_IDX_WIDTH'(SLV_CNT - 1);

   typedef enum logic {ST_ARB, ST_HOLD} state_t;

   state_t                   state;
   logic [SLV_IDX_WIDTH-1:0] ptr;
   logic [SLV_IDX_WIDTH-1:0] gnt;
   logic [CNT_W-1:0]         cnt;

   logic [SLV_CNT-1:0]       slv_vld;
   logic [SLV_CNT-1:0]       slv_rdy;
   DTYPE                     slv_data [SLV_CNT];

   logic                     arb_hit;
   logic [SLV_IDX_WIDTH-1:0] arb_sel;
   logic [SLV_IDX_WIDTH-1:0] cand;
   logic [SLV_IDX_WIDTH-1:0] cur_src;
   logic                     cur_vld;
   logic                     granted;
   logic                     egr_rdy;
   logic                     xfer;
   logic                     last_beat;
   logic                     release_gnt;

   // Flatten the interface array so the rest of the logic can index it.
   for (genvar i = 0; i < SLV_CNT; i++) begin : g_slv
      assign slv_vld[i]     = if_slv[i].vld;
      assign slv_data[i]    = if_slv[i].data;
      assign if_slv[i].rdy  = slv_rdy[i];
   end

   // Round-robin search: first valid source at or after ptr+1, wrapping.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      arb_hit = 1'b0;
      arb_sel = '0;
      cand    = '0;
      for (int k = 1; k <= SLV_CNT; k++) begin
         cand = SLV_IDX_WIDTH'((int'(ptr) + k) % SLV_CNT);
         if (!arb_hit && slv_vld[cand]) begin
            arb_hit = 1'b1;
            arb_sel = cand;
         end
      end
   end

   // In HOLD the stored grant is used; in ARB the search result is granted at once.
   assign cur_src   = (state == ST_HOLD) ? gnt : arb_sel;
   assign cur_vld   = i_rst_n && ((state == ST_HOLD) ? slv_vld[gnt] : arb_hit);
   assign granted   = i_rst_n && ((state == ST_HOLD) || arb_hit);
   assign xfer      = cur_vld && egr_rdy;
   assign last_beat = (cnt == LAST_CNT);

   // A held grant ends on its final burst beat, or when the source idles after sending.
   assign release_gnt = (state == ST_HOLD) &&
                        ((xfer && last_beat) || (!slv_vld[gnt] && (cnt != '0)));

   // Only the granted source ever sees ready.
   always_comb begin
      slv_rdy          = '0;
      slv_rdy[cur_src] = granted && egr_rdy;
   end

   // Grant FSM: pointer, held grant and burst beat counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: sequential state is updated with non-blocking assignments only.
         state <= ST_ARB;
         ptr   <= PTR_RST;
         gnt   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_ARB: begin
               if (arb_hit) begin
                  if (xfer && last_beat) begin
                     ptr <= arb_sel;
                  end else begin
                     state <= ST_HOLD;
                     gnt   <= arb_sel;
                     cnt   <= cnt + CNT_W'(xfer);
                  end
               end
            end
            ST_HOLD: begin
               if (release_gnt) begin
                  state <= ST_ARB;
                  ptr   <= gnt;
                  cnt   <= '0;
               end else if (xfer) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= ST_ARB;
         endcase
      end
   end

`ifdef DS_ARB_SKID_EN

   logic [1:0]               sk_cnt;
   logic                     sk_wr;
   logic                     sk_rd;
   logic                     sk_vld;
   logic                     sk_pop;
   DTYPE                     sk_data [2];
   logic [SLV_IDX_WIDTH-1:0] sk_src  [2];

   // Ingress acceptance depends only on registered occupancy, never on if_mst.rdy.
   assign egr_rdy = (sk_cnt != 2'd2);
   assign sk_vld  = (sk_cnt != 2'd0);
   assign sk_pop  = sk_vld && if_mst.rdy;

   // Skid occupancy and pointers; cleared by reset so held beats are discarded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sk_cnt <= '0;
         sk_wr  <= 1'b0;
         sk_rd  <= 1'b0;
      end else begin
         if (xfer)   sk_wr <= ~sk_wr;
         if (sk_pop) sk_rd <= ~sk_rd;
         sk_cnt <= sk_cnt + 2'(xfer) - 2'(sk_pop);
      end
   end

   // Skid payload storage.
   always_ff @(posedge i_clk) begin
      // NOTE: storage is not reset; the reset occupancy count already marks every entry invalid.
      if (xfer) begin
         sk_data[sk_wr] <= slv_data[cur_src];
         sk_src[sk_wr]  <= cur_src;
      end
   end

   assign if_mst.vld  = sk_vld;
   assign if_mst.data = sk_data[sk_rd];
   assign o_mst_src   = sk_vld ? sk_src[sk_rd] : '0;

`else

   assign egr_rdy     = if_mst.rdy;
   assign if_mst.vld  = cur_vld;
   assign if_mst.data = slv_data[cur_src];
   assign o_mst_src   = i_rst_n ? cur_src : '0;

`endif

endmodule

// File: tb/tb_ds_arb.sv
// tb_ds_arb: directed bench for ds_arb (default build, combinational egress).
// Three instances: BURST_MAX = 1, 4 and 8, four 8-bit sources each.
module tb_ds_arb;

   localparam int N  = 4;
   localparam int ND = 3;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic       s_vld [ND][N];
   logic [7:0] s_dat [ND][N];
   logic       s_rdy [ND][N];
   logic       m_vld [ND];
   logic       m_rdy [ND];
   logic [7:0] m_dat [ND];
   logic [1:0] m_src [ND];

   for (genvar d = 0; d < ND; d++) begin : g_dut
      localparam int BM = (d == 0) ? 1 : (d == 1) ? 4 : 8;

      ds_if #(.DTYPE(logic [7:0])) s_if [N-1:0] ();
      ds_if #(.DTYPE(logic [7:0])) m_if ();

      for (genvar i = 0; i < N; i++) begin : g_src
         assign s_if[i].vld  = s_vld[d][i];
         assign s_if[i].data = s_dat[d][i];
         assign s_rdy[d][i]  = s_if[i].rdy;
      end
      assign m_if.rdy = m_rdy[d];
      assign m_vld[d] = m_if.vld;
      assign m_dat[d] = m_if.data;

      ds_arb #(
         .SLV_CNT   (N),
         .DTYPE     (logic [7:0]),
         .BURST_MAX (BM)
      ) u_dut (
         .i_clk     (clk),
         .i_rst_n   (rst_n),
         .if_slv    (s_if),
         .if_mst    (m_if),
         .o_mst_src (m_src[d])
      );
   end

   typedef struct {
      int src;
      int dat;
      int cyc;
   } beat_t;

   int         cur;
   bit         want_rdy;
   int         rem  [N];
   int         sent [N];
   logic [7:0] base [N];
   int         cyc;
   beat_t      log_q [$];
   logic       o_vld;
   logic [1:0] o_src;
   logic [7:0] o_dat;
   int         o_rdy_cnt;
   int         total;
   int         bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int rdy_cnt(input int d);
      int n;
      n = 0;
      for (int i = 0; i < N; i++) if (s_rdy[d][i] === 1'b1) n++;
      return n;
   endfunction

   // Present every source's next beat to the selected instance; others idle.
   task automatic drive();
      for (int d = 0; d < ND; d++) begin
         m_rdy[d] = (d == cur) ? want_rdy : 1'b0;
         for (int i = 0; i < N; i++) begin
            s_vld[d][i] = (d == cur) && (rem[i] > 0);
            s_dat[d][i] = base[i] + 8'(sent[i]);
         end
      end
   endtask

   // Sample before the edge: log egress beats and advance sources that handshake.
   task automatic observe();
      o_vld     = m_vld[cur];
      o_src     = m_src[cur];
      o_dat     = m_dat[cur];
      o_rdy_cnt = rdy_cnt(cur);
      if (rst_n && o_vld && m_rdy[cur])
         log_q.push_back('{src: int'(o_src), dat: int'(o_dat), cyc: cyc});
      for (int i = 0; i < N; i++) begin
         if (rst_n && s_vld[cur][i] && s_rdy[cur][i]) begin
            rem[i]--;
            sent[i]++;
         end
      end
   endtask

   task automatic cycle();
      drive();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         rem[i]  = 0;
         sent[i] = 0;
         base[i] = 8'(i * 16);
      end
   endtask

   task automatic do_reset(input int d);
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      cur      = d;
      want_rdy = 1'b0;
      clear_src();
      drive();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      log_q.delete();
      cyc = 0;
   endtask

   task automatic check_beat(input string tag, input int k, input int es, input int ed, input int ec);
      check({tag, "_src"}, log_q[k].src, es);
      check({tag, "_dat"}, log_q[k].dat, ed);
      check({tag, "_cyc"}, log_q[k].cyc, ec);
   endtask

   initial begin
      int exp_src [20];
      int n_from  [N];

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      cur   = 0;
      cyc   = 0;
      want_rdy = 1'b0;
      clear_src();
      drive();

      // Reset with every source valid, then rotation with BURST_MAX=1.
      @(posedge clk);
      #1;
      want_rdy = 1'b1;
      for (int i = 0; i < N; i++) rem[i] = 100;
      drive();
      #2;
      check("rst_mvld", m_vld[0], 1'b0);
      check("rst_rdy",  rdy_cnt(0), 0);
      check("rst_src",  m_src[0], 2'd0);
      @(posedge clk);
      #1;
      check("rst_mvld_edge", m_vld[0], 1'b0);
      rst_n = 1'b1;
      log_q.delete();
      cyc = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("rot_rdy", o_rdy_cnt, 1);
      end
      check("rot_n", log_q.size(), 8);
      for (int k = 0; k < 8 && k < log_q.size(); k++)
         check_beat("rot", k, k % 4, (k % 4) * 16 + k / 4, k);

      // Bursts of 4 alternating between sources 1 and 2, ten beats each.
      do_reset(1);
      want_rdy = 1'b1;
      rem[1] = 10;
      rem[2] = 10;
      exp_src = '{1,1,1,1, 2,2,2,2, 1,1,1,1, 2,2,2,2, 1,1, 2,2};
      repeat (30) cycle();
      check("burst_n", log_q.size(), 20);
      for (int i = 0; i < N; i++) n_from[i] = 0;
      for (int k = 0; k < 20 && k < log_q.size(); k++) begin
         check("burst_src", log_q[k].src, exp_src[k]);
         check("burst_dat", log_q[k].dat, exp_src[k] * 16 + n_from[exp_src[k]]);
         n_from[exp_src[k]]++;
      end

      // Egress stall while source 3 holds 0xA5 and source 0 starts requesting.
      do_reset(0);
      base[3] = 8'hA5;
      rem[3]  = 1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (k == 0) rem[0] = 1;
         check("stall_vld", o_vld, 1'b1);
         check("stall_dat", o_dat, 8'hA5);
         check("stall_src", o_src, 2'd3);
      end
      check("stall_nobeat", log_q.size(), 0);
      want_rdy = 1'b1;
      repeat (4) cycle();
      check("stall_n", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check_beat("stall_b0", 0, 3, 8'hA5, 6);
         check_beat("stall_b1", 1, 0, 8'h00, 7);
      end

      // Early release with BURST_MAX=8: source 2 sends 3 beats, then source 0.
      do_reset(2);
      want_rdy = 1'b1;
      rem[2] = 3;
      cycle();
      rem[0] = 2;
      repeat (7) cycle();
      check("early_n", log_q.size(), 5);
      if (log_q.size() == 5) begin
         check_beat("early_b0", 0, 2, 8'h20, 0);
         check_beat("early_b1", 1, 2, 8'h21, 1);
         check_beat("early_b2", 2, 2, 8'h22, 2);
         check_beat("early_b3", 3, 0, 8'h00, 4);
         check_beat("early_b4", 4, 0, 8'h01, 5);
      end

      // Reset during beat 2 of a 4-beat burst; nothing stale may follow.
      do_reset(1);
      want_rdy = 1'b1;
      rem[1] = 4;
      cycle();
      check("mrst_pre_n", log_q.size(), 1);
      drive();
      rst_n = 1'b0;
      #2;
      check("mrst_mvld", m_vld[1], 1'b0);
      check("mrst_rdy",  rdy_cnt(1), 0);
      check("mrst_src",  m_src[1], 2'd0);
      @(posedge clk);
      #1;
      check("mrst_mvld_edge", m_vld[1], 1'b0);
      rem[1] = 0;
      rem[2] = 1;
      rem[3] = 1;
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      log_q.delete();
      cyc = 0;
      repeat (5) cycle();
      check("mrst_n", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check_beat("mrst_b0", 0, 2, 8'h20, 0);
         check_beat("mrst_b1", 1, 3, 8'h30, 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
